rgb_pwm_driver: RTL

RGB_PWM_DRIVER -- requirements
Module: rgb_pwm_driver

---
 rtl/rgb_pwm_driver.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/rgb_pwm_driver.sv
// RGB LED PWM driver.
// Loads three 8-bit duties from a 24-bit colour code scaled by a master
// brightness, then runs 255-step PWM frames paced by a clock prescaler.
// The run request is honoured only from IDLE or at a frame boundary, so a
// started frame always completes.
//
//   state | meaning
//   IDLE  | counters and duties cleared, outputs low, waiting for enable
//   RUN   | frames running, duties reloaded at each boundary while enabled
module rgb_pwm_driver #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [23:0] light,
    input  logic [7:0]  dim,
    output logic        pwm_r,
    output logic        pwm_g,
    output logic        pwm_b,
    output logic        frame_start,
    output logic        busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);
    localparam logic [7:0]  CNT_LAST  = 8'd254;

    state_t      state_q, state_d;
    logic [15:0] presc_q, presc_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  duty_r_q, duty_r_d;
    logic [7:0]  duty_g_q, duty_g_d;
    logic [7:0]  duty_b_q, duty_b_d;
    logic        pwm_r_q, pwm_g_q, pwm_b_q;
    logic        pwm_r_d, pwm_g_d, pwm_b_d;
    logic        fs_q, fs_d;
    logic        tick;
    logic        load;

    // Brightness scaling: (c * (dim + 1)) >> 8, so dim = FF passes c unchanged.
    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] d);
        logic [16:0] prod;
        prod = 17'(c) * 17'({1'b0, d} + 9'd1);
        return prod[15:8];
    endfunction

    // Next-state logic: prescaler, frame counter, duty loads and FSM transitions.
    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        cnt_d    = cnt_q;
        duty_r_d = duty_r_q;
        duty_g_d = duty_g_q;
        duty_b_d = duty_b_q;
        fs_d     = 1'b0;
        load     = 1'b0;
        tick     = (presc_q == PRESC_MAX);

        case (state_q)
            IDLE: begin
                presc_d  = '0;
                cnt_d    = '0;
                duty_r_d = '0;
                duty_g_d = '0;
                duty_b_d = '0;
                if (enable) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                presc_d = tick ? 16'd0 : presc_q + 16'd1;
                if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (enable) begin
                            load = 1'b1;
                        end else begin
                            state_d  = IDLE;
                            presc_d  = '0;
                            duty_r_d = '0;
                            duty_g_d = '0;
                            duty_b_d = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            duty_r_d = scale(light[23:16], dim);
            duty_g_d = scale(light[15:8],  dim);
            duty_b_d = scale(light[7:0],   dim);
            cnt_d    = '0;
            presc_d  = '0;
            fs_d     = 1'b1;
        end

        // Compare uses the current count, so the outputs trail cnt by one clock.
        pwm_r_d = (state_q == RUN) && (cnt_q < duty_r_q);
        pwm_g_d = (state_q == RUN) && (cnt_q < duty_g_q);
        pwm_b_d = (state_q == RUN) && (cnt_q < duty_b_q);
    end

    // State and output registers, cleared asynchronously so reset never glitches an LED on.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            cnt_q    <= '0;
            duty_r_q <= '0;
            duty_g_q <= '0;
            duty_b_q <= '0;
            pwm_r_q  <= 1'b0;
            pwm_g_q  <= 1'b0;
            pwm_b_q  <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            cnt_q    <= cnt_d;
            duty_r_q <= duty_r_d;
            duty_g_q <= duty_g_d;
            duty_b_q <= duty_b_d;
            pwm_r_q  <= pwm_r_d;
            pwm_g_q  <= pwm_g_d;
            pwm_b_q  <= pwm_b_d;
            fs_q     <= fs_d;
        end
    end

    assign pwm_r       = pwm_r_q;
    assign pwm_g       = pwm_g_q;
    assign pwm_b       = pwm_b_q;
    assign frame_start = fs_q;
    assign busy        = (state_q == RUN);

endmodule
